// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (compute) -> RESP (handshake).
module alu_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [6:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [6:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,

    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,

    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,

    output logic [7:0] alu_in1,
    output logic [7:0] alu_in2,
    output logic [1:0] alu_op,
    output logic [1:0] alu_branch_sel,
    output logic       alu_sub,
    output logic       alu_branch,
    output logic       alu_shift_left,
    input  logic [7:0] alu_out,

    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;

    logic       last_grant_r;
    logic       owner_r;
    logic [6:0] op_r;
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic [7:0] result_r;

    logic       winner_s;
    logic       accept_s;
    logic       rsp_ack_s;

    // Winner selection; only meaningful while some request is valid.
    always_comb begin
        winner_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (RR_EN != 0) begin
                winner_s = ~last_grant_r;
            end else begin
                winner_s = 1'b0;
            end
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Response handshake comes from whichever requester owns the operation.
    always_comb begin
        if (owner_r) begin
            rsp_ack_s = rsp1_ready;
        end else begin
            rsp_ack_s = rsp0_ready;
        end
    end

    // Next-state and handshake outputs; ready is gated by rst_n so it drops during reset.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        busy        = 1'b1;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept_s    = 1'b1;
                    state_nxt_s = EXEC;
                    if (winner_s) begin
                        req1_ready = 1'b1;
                    end else begin
                        req0_ready = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (owner_r) begin
                    rsp1_valid = 1'b1;
                end else begin
                    rsp0_valid = 1'b1;
                end
                if (rsp_ack_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                busy        = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Result data is forced to zero whenever its valid is low.
    always_comb begin
        rsp0_data = 8'd0;
        rsp1_data = 8'd0;
        if (rsp0_valid) begin
            rsp0_data = result_r;
        end else begin
            rsp0_data = 8'd0;
        end
        if (rsp1_valid) begin
            rsp1_data = result_r;
        end else begin
            rsp1_data = 8'd0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant history and current owner; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
        end else if (accept_s) begin
            last_grant_r <= winner_s;
            owner_r      <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
            owner_r      <= owner_r;
        end
    end

    // Operation capture; these registers only move on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 7'd0;
            a_r  <= 8'd0;
            b_r  <= 8'd0;
        end else if (accept_s) begin
            if (winner_s) begin
                op_r <= req1_op;
                a_r  <= req1_a;
                b_r  <= req1_b;
            end else begin
                op_r <= req0_op;
                a_r  <= req0_a;
                b_r  <= req0_b;
            end
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
        end
    end

    // ALU result is sampled at the closing edge of the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= 8'd0;
        end else if (state_r == EXEC) begin
            result_r <= alu_out;
        end else begin
            result_r <= result_r;
        end
    end

    assign alu_in1        = a_r;
    assign alu_in2        = b_r;
    assign alu_op         = op_r[6:5];
    assign alu_branch_sel = op_r[4:3];
    assign alu_sub        = op_r[2];
    assign alu_branch     = op_r[1];
    assign alu_shift_left = op_r[0];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal results, then randomized traffic
// checked every cycle against a transaction-level model; a second instance covers fixed priority.
module tb_alu_arbiter;

    localparam int RR = 1;
    localparam logic [6:0] OP_ADD = 7'b0000000;
    localparam logic [6:0] OP_SUB = 7'b0000100;
    localparam logic [6:0] OP_XOR = 7'b1100000;
    localparam logic [6:0] OP_BLT = 7'b0001110;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [6:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] alu_in1, alu_in2, alu_out;
    logic [1:0] alu_op, alu_branch_sel;
    logic       alu_sub, alu_branch, alu_shift_left, busy;

    logic       f_req0_valid, f_req1_valid, f_req0_ready, f_req1_ready;
    logic [6:0] f_req0_op, f_req1_op;
    logic [7:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
    logic       f_rsp0_valid, f_rsp1_valid, f_rsp0_ready, f_rsp1_ready;
    logic [7:0] f_rsp0_data, f_rsp1_data;
    logic [7:0] f_alu_in1, f_alu_in2, f_alu_out;
    logic [1:0] f_alu_op, f_alu_branch_sel;
    logic       f_alu_sub, f_alu_branch, f_alu_shift_left, f_busy;

    int total = 0;
    int bad   = 0;

    // Reference ALU: 00 add/sub or branch compare, 01 shift, 10 and, 11 xor.
    function automatic logic [7:0] alu_ref(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       c;
        c = 1'b0;
        case (op[6:5])
            2'd0: begin
                if (op[1]) begin
                    case (op[4:3])
                        2'd0:    c = (a == b);
                        2'd1:    c = (a < b);
                        2'd2:    c = (a != b);
                        default: c = (a >= b);
                    endcase
                    r = {7'd0, c};
                end else if (op[2]) begin
                    r = a - b;
                end else begin
                    r = a + b;
                end
            end
            2'd1:    r = op[0] ? (a << b[2:0]) : (a >> b[2:0]);
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign alu_out   = alu_ref({alu_op, alu_branch_sel, alu_sub, alu_branch, alu_shift_left}, alu_in1, alu_in2);
    assign f_alu_out = alu_ref({f_alu_op, f_alu_branch_sel, f_alu_sub, f_alu_branch, f_alu_shift_left}, f_alu_in1, f_alu_in2);

    alu_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_branch_sel(alu_branch_sel),
        .alu_sub(alu_sub), .alu_branch(alu_branch), .alu_shift_left(alu_shift_left),
        .alu_out(alu_out), .busy(busy)
    );

    alu_arbiter #(.RR_EN(0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(f_req0_op), .req0_a(f_req0_a), .req0_b(f_req0_b),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(f_req1_op), .req1_a(f_req1_a), .req1_b(f_req1_b),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_data(f_rsp0_data),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_data(f_rsp1_data),
        .alu_in1(f_alu_in1), .alu_in2(f_alu_in2), .alu_op(f_alu_op), .alu_branch_sel(f_alu_branch_sel),
        .alu_sub(f_alu_sub), .alu_branch(f_alu_branch), .alu_shift_left(f_alu_shift_left),
        .alu_out(f_alu_out), .busy(f_busy)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one operation in flight; result visible after one compute cycle.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            if (RR != 0) return (last == 1'b1) ? 1'b0 : 1'b1;
            return 1'b0;
        end
        return v0 ? 1'b0 : 1'b1;
    endfunction

    logic       m_busy, m_computed, m_owner, m_last;
    logic [6:0] m_op;
    logic [7:0] m_a, m_b, m_res;
    logic       exp_win;
    assign exp_win = pick(req0_valid, req1_valid, m_last);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_computed <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
            m_op <= 7'd0; m_a <= 8'd0; m_b <= 8'd0; m_res <= 8'd0;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy <= 1'b1; m_computed <= 1'b0;
                m_owner <= exp_win; m_last <= exp_win;
                m_op <= exp_win ? req1_op : req0_op;
                m_a  <= exp_win ? req1_a : req0_a;
                m_b  <= exp_win ? req1_b : req0_b;
            end
        end else if (!m_computed) begin
            m_computed <= 1'b1;
            m_res <= alu_ref(m_op, m_a, m_b);
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy <= 1'b0;
        end
    end

    logic       e_rdy0, e_rdy1, e_rv0, e_rv1;
    assign e_rdy0 = rst_n && !m_busy && (req0_valid || req1_valid) && (exp_win == 1'b0);
    assign e_rdy1 = rst_n && !m_busy && (req0_valid || req1_valid) && (exp_win == 1'b1);
    assign e_rv0  = m_busy && m_computed && !m_owner;
    assign e_rv1  = m_busy && m_computed && m_owner;

    // Every-cycle comparison of the round-robin instance against the model.
    always @(negedge clk) begin
        chk1("req0_ready", req0_ready, e_rdy0);
        chk1("req1_ready", req1_ready, e_rdy1);
        chk1("rsp0_valid", rsp0_valid, e_rv0);
        chk1("rsp1_valid", rsp1_valid, e_rv1);
        chk8("rsp0_data", rsp0_data, e_rv0 ? m_res : 8'd0);
        chk8("rsp1_data", rsp1_data, e_rv1 ? m_res : 8'd0);
        chk1("busy", busy, m_busy);
        chk8("alu_in1", alu_in1, m_a);
        chk8("alu_in2", alu_in2, m_b);
        chk8("alu_ctl", {1'b0, alu_op, alu_branch_sel, alu_sub, alu_branch, alu_shift_left}, {1'b0, m_op});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic n, input logic v, input logic [6:0] op, input logic [7:0] a, input logic [7:0] b);
        if (n) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    function automatic logic rdy(input logic n);
        return n ? req1_ready : req0_ready;
    endfunction

    function automatic logic rv(input logic n);
        return n ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [7:0] rd(input logic n);
        return n ? rsp1_data : rsp0_data;
    endfunction

    task automatic wait_ready(input logic n, input int budget, input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rdy(n)) got = 1'b1;
        end
        chk1({nm, "_ready"}, got, 1'b1);
    endtask

    task automatic wait_rsp(input logic n, input logic [7:0] exp, input int budget, input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rv(n)) got = 1'b1;
        end
        chk1({nm, "_rsp_seen"}, got, 1'b1);
        chk8({nm, "_rsp_data"}, rd(n), exp);
    endtask

    // Called at posedge+1 in IDLE; checks the 2-cycle latency exactly and returns in IDLE.
    task automatic run_op(input logic n, input logic [6:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input string nm);
        drive(n, 1'b1, op, a, b);
        wait_ready(n, 20, nm);
        tick();
        drive(n, 1'b0, op, a, b);
        @(negedge clk);
        chk1({nm, "_exec_valid"}, rv(n), 1'b0);
        @(negedge clk);
        chk1({nm, "_rsp_valid"}, rv(n), 1'b1);
        chk8({nm, "_rsp_data"}, rd(n), exp);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc0, acc1;
        int   grants;
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 7'd0, 8'd0, 8'd0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        f_req0_op = OP_ADD; f_req0_a = 8'd5; f_req0_b = 8'd6;
        f_req1_op = OP_ADD; f_req1_a = 8'd1; f_req1_b = 8'd1;
        f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk8("reset_alu_in1", alu_in1, 8'd0);
        chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();

        run_op(1'b0, OP_ADD, 8'd10, 8'd15, 8'd25, "add");

        do_reset();
        drive(1'b0, 1'b1, OP_SUB, 8'd20, 8'd5);
        drive(1'b1, 1'b1, OP_XOR, 8'hF0, 8'hAA);
        wait_ready(1'b0, 2, "tie_a");
        chk1("tie_a_loser", req1_ready, 1'b0);
        tick();
        drive(1'b0, 1'b0, OP_SUB, 8'd20, 8'd5);
        wait_rsp(1'b0, 8'd15, 5, "tie_a");
        wait_ready(1'b1, 2, "tie_b");
        tick();
        drive(1'b1, 1'b1, OP_XOR, 8'h0F, 8'hFF);
        drive(1'b0, 1'b1, OP_ADD, 8'd1, 8'd2);
        wait_rsp(1'b1, 8'h5A, 5, "tie_b");
        wait_ready(1'b0, 2, "tie_c");
        chk1("tie_c_loser", req1_ready, 1'b0);
        tick();
        drive(1'b0, 1'b0, OP_ADD, 8'd1, 8'd2);
        wait_rsp(1'b0, 8'd3, 5, "tie_c");
        wait_ready(1'b1, 2, "tie_d");
        tick();
        drive(1'b1, 1'b0, OP_XOR, 8'h0F, 8'hFF);
        wait_rsp(1'b1, 8'hF0, 5, "tie_d");
        tick();

        run_op(1'b1, OP_BLT, 8'd10, 8'd20, 8'd1, "blt_lt");
        run_op(1'b1, OP_BLT, 8'd42, 8'd42, 8'd0, "blt_eq");

        rsp0_ready = 1'b0;
        drive(1'b0, 1'b1, OP_ADD, 8'd7, 8'd8);
        wait_ready(1'b0, 5, "stall");
        tick();
        drive(1'b0, 1'b0, OP_ADD, 8'd7, 8'd8);
        drive(1'b1, 1'b1, OP_XOR, 8'd1, 8'd3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_valid", rsp0_valid, 1'b1);
            chk8("stall_data", rsp0_data, 8'd15);
            chk1("stall_r1", req1_ready, 1'b0);
            chk1("stall_busy", busy, 1'b1);
        end
        tick();
        rsp0_ready = 1'b1;
        wait_ready(1'b1, 3, "stall_next");
        tick();
        drive(1'b1, 1'b0, OP_XOR, 8'd1, 8'd3);
        wait_rsp(1'b1, 8'd2, 5, "stall_next");
        tick();

        drive(1'b0, 1'b1, OP_ADD, 8'd100, 8'd1);
        wait_ready(1'b0, 5, "mid_rst");
        tick();
        drive(1'b0, 1'b0, OP_ADD, 8'd100, 8'd1);
        drive(1'b1, 1'b1, OP_ADD, 8'd9, 8'd9);
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_r1", req1_ready, 1'b0);
        chk1("rst_rsp0", rsp0_valid, 1'b0);
        chk8("rst_in1", alu_in1, 8'd0);
        chk8("rst_in2", alu_in2, 8'd0);
        tick();
        drive(1'b1, 1'b0, OP_ADD, 8'd9, 8'd9);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_no_rsp", rsp0_valid, 1'b0);
        tick();
        run_op(1'b0, OP_ADD, 8'd3, 8'd4, 8'd7, "post_rst");

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (c == 1500) do_reset();
            if (acc0 || !req0_valid)
                drive(1'b0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom), 8'($urandom));
            if (acc1 || !req1_valid)
                drive(1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 8'($urandom), 8'($urandom));
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
        end

        @(negedge clk);
        tick();
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 7'd0, 8'd0, 8'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        f_req0_valid = 1'b1; f_req1_valid = 1'b1;
        grants = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (f_req0_ready) grants++;
            chk1("fix_r1", f_req1_ready, 1'b0);
            chk1("fix_rsp1", f_rsp1_valid, 1'b0);
            if (f_rsp0_valid) chk8("fix_data", f_rsp0_data, 8'd11);
        end
        chki("fix_grants", grants, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
